// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register and EX operand-select stage.
//
// The stage captures, from ID, the decoded control bits, the register read
// data, the immediate and the register addresses. The registered Rs/Rt
// addresses go to the forwarding unit. The forwarding selects that come back
// choose the final ALU operands and the store data. The stage also flags a
// load-use hazard against the instruction currently sitting in ID.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   stall_i, flush_i        hold all state / load a bubble (flush has priority)
//   *_i (ID side)           control, data, immediate and addresses from ID;
//                           these are captured only, never passed straight
//                           through to an output
//   IF_ID_RsAddr_i/RtAddr_i source addresses of the instruction now in ID
//   EX_RsOverride_i/Rt..    forwarding selects: 00 reg, 10 EX/MEM,
//                           01 MEM/WB, 11 treated as 00
//   EX_MEM_ALUResult_i      EX/MEM forward value
//   MEM_WB_WriteData_i      MEM/WB forward value
//   ID_EX_*Addr_o           registered register addresses
//   RegWrite_o..funct_o     registered control fields
//   valid_o                 stage holds a real instruction
//   ALUSrcA_o, ALUSrcB_o    final ALU operands
//   StoreData_o             forwarded Rt value for stores
//   hazard_o                load-use hazard against the instruction in ID
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [9:0]        funct_i,
    input  logic [DATA_W-1:0] RsData_i,
    input  logic [DATA_W-1:0] RtData_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [ADDR_W-1:0] RsAddr_i,
    input  logic [ADDR_W-1:0] RtAddr_i,
    input  logic [ADDR_W-1:0] RdAddr_i,
    input  logic [ADDR_W-1:0] IF_ID_RsAddr_i,
    input  logic [ADDR_W-1:0] IF_ID_RtAddr_i,
    input  logic [1:0]        EX_RsOverride_i,
    input  logic [1:0]        EX_RtOverride_i,
    input  logic [DATA_W-1:0] EX_MEM_ALUResult_i,
    input  logic [DATA_W-1:0] MEM_WB_WriteData_i,
    output logic [ADDR_W-1:0] ID_EX_RsAddr_o,
    output logic [ADDR_W-1:0] ID_EX_RtAddr_o,
    output logic [ADDR_W-1:0] ID_EX_RdAddr_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic [9:0]        funct_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] ALUSrcA_o,
    output logic [DATA_W-1:0] ALUSrcB_o,
    output logic [DATA_W-1:0] StoreData_o,
    output logic              hazard_o
);

    // The whole pipeline register as one bank. All-zero is the bubble
    // encoding. Zero addresses can never match a live forwarding source,
    // because x0 is never forwarded.
    typedef struct packed {
        logic              valid;
        logic              regWrite;
        logic              memtoReg;
        logic              memRead;
        logic              memWrite;
        logic              aluSrc;
        logic [1:0]        aluOp;
        logic [9:0]        funct;
        logic [DATA_W-1:0] rsData;
        logic [DATA_W-1:0] rtData;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] rsAddr;
        logic [ADDR_W-1:0] rtAddr;
        logic [ADDR_W-1:0] rdAddr;
    } idExReg_t;

    idExReg_t stageQ;
    idExReg_t loadVal;
    logic [DATA_W-1:0] fwdRs;
    logic [DATA_W-1:0] fwdRt;

    always_comb begin
        loadVal = '{
            valid:    1'b1,
            regWrite: RegWrite_i,
            memtoReg: MemtoReg_i,
            memRead:  MemRead_i,
            memWrite: MemWrite_i,
            aluSrc:   ALUSrc_i,
            aluOp:    ALUOp_i,
            funct:    funct_i,
            rsData:   RsData_i,
            rtData:   RtData_i,
            imm:      Imm_i,
            rsAddr:   RsAddr_i,
            rtAddr:   RtAddr_i,
            rdAddr:   RdAddr_i
        };
    end

    // Priority: async reset, then flush (a flush overrides a stall), then
    // stall, then load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments for registered state, so every flop
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            stageQ <= '0;
        end else if (flush_i) begin
            stageQ <= '0;
        end else if (!stall_i) begin
            stageQ <= loadVal;
        end
    end

    // Forwarding mux. Select 11 is illegal and falls through to the
    // registered value.
    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no
        // latch is inferred.
        fwdRs = stageQ.rsData;
        fwdRt = stageQ.rtData;
        case (EX_RsOverride_i)
            2'b10:   fwdRs = EX_MEM_ALUResult_i;
            2'b01:   fwdRs = MEM_WB_WriteData_i;
            default: ;
        endcase
        case (EX_RtOverride_i)
            2'b10:   fwdRt = EX_MEM_ALUResult_i;
            2'b01:   fwdRt = MEM_WB_WriteData_i;
            default: ;
        endcase
    end

    assign ALUSrcA_o   = fwdRs;
    assign StoreData_o = fwdRt;
    assign ALUSrcB_o   = stageQ.aluSrc ? stageQ.imm : fwdRt;

    // A load in EX whose destination (Rt) feeds the instruction in ID.
    // A load into x0 is harmless, and a bubble never raises a hazard.
    assign hazard_o = stageQ.valid & stageQ.memRead & (stageQ.rtAddr != '0) &
                      ((stageQ.rtAddr == IF_ID_RsAddr_i) |
                       (stageQ.rtAddr == IF_ID_RtAddr_i));

    assign ID_EX_RsAddr_o = stageQ.rsAddr;
    assign ID_EX_RtAddr_o = stageQ.rtAddr;
    assign ID_EX_RdAddr_o = stageQ.rdAddr;
    assign RegWrite_o     = stageQ.regWrite;
    assign MemtoReg_o     = stageQ.memtoReg;
    assign MemRead_o      = stageQ.memRead;
    assign MemWrite_o     = stageQ.memWrite;
    assign ALUSrc_o       = stageQ.aluSrc;
    assign ALUOp_o        = stageQ.aluOp;
    assign funct_o        = stageQ.funct;
    assign valid_o        = stageQ.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. It uses two tables: forwarding/operand
// vectors and load-use vectors. Hand-written sequences cover reset, stall,
// flush and asynchronous reset. A randomized run is checked against a
// behavioural model of the stage's contents.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          stall_i, flush_i;
    logic          RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
    logic [1:0]    ALUOp_i;
    logic [9:0]    funct_i;
    logic [DW-1:0] RsData_i, RtData_i, Imm_i;
    logic [AW-1:0] RsAddr_i, RtAddr_i, RdAddr_i;
    logic [AW-1:0] IF_ID_RsAddr_i, IF_ID_RtAddr_i;
    logic [1:0]    EX_RsOverride_i, EX_RtOverride_i;
    logic [DW-1:0] EX_MEM_ALUResult_i, MEM_WB_WriteData_i;
    logic [AW-1:0] ID_EX_RsAddr_o, ID_EX_RtAddr_o, ID_EX_RdAddr_o;
    logic          RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
    logic [1:0]    ALUOp_o;
    logic [9:0]    funct_o;
    logic          valid_o;
    logic [DW-1:0] ALUSrcA_o, ALUSrcB_o, StoreData_o;
    logic          hazard_o;

    id_ex_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .funct_i(funct_i), .RsData_i(RsData_i), .RtData_i(RtData_i), .Imm_i(Imm_i),
        .RsAddr_i(RsAddr_i), .RtAddr_i(RtAddr_i), .RdAddr_i(RdAddr_i),
        .IF_ID_RsAddr_i(IF_ID_RsAddr_i), .IF_ID_RtAddr_i(IF_ID_RtAddr_i),
        .EX_RsOverride_i(EX_RsOverride_i), .EX_RtOverride_i(EX_RtOverride_i),
        .EX_MEM_ALUResult_i(EX_MEM_ALUResult_i), .MEM_WB_WriteData_i(MEM_WB_WriteData_i),
        .ID_EX_RsAddr_o(ID_EX_RsAddr_o), .ID_EX_RtAddr_o(ID_EX_RtAddr_o),
        .ID_EX_RdAddr_o(ID_EX_RdAddr_o), .RegWrite_o(RegWrite_o),
        .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o), .funct_o(funct_o), .valid_o(valid_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .StoreData_o(StoreData_o),
        .hazard_o(hazard_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: the instruction the stage currently holds (all-zero = bubble).
    typedef struct packed {
        logic          valid;
        logic          rw, mtr, mr, mw, as;
        logic [1:0]    op;
        logic [9:0]    fn;
        logic [DW-1:0] rs, rt, imm;
        logic [AW-1:0] rsa, rta, rda;
    } inst_t;

    inst_t model;
    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic inst_t capture_id();
        inst_t t;
        t.valid = 1'b1;
        t.rw = RegWrite_i; t.mtr = MemtoReg_i; t.mr = MemRead_i;
        t.mw = MemWrite_i; t.as = ALUSrc_i; t.op = ALUOp_i; t.fn = funct_i;
        t.rs = RsData_i; t.rt = RtData_i; t.imm = Imm_i;
        t.rsa = RsAddr_i; t.rta = RtAddr_i; t.rda = RdAddr_i;
        return t;
    endfunction

    function automatic logic [DW-1:0] exp_fwd(input logic [1:0] sel, input logic [DW-1:0] regv);
        if (sel == 2'b10) return EX_MEM_ALUResult_i;
        if (sel == 2'b01) return MEM_WB_WriteData_i;
        return regv;
    endfunction

    function automatic logic exp_hazard();
        return model.valid && model.mr && (model.rta != 0) &&
               (model.rta == IF_ID_RsAddr_i || model.rta == IF_ID_RtAddr_i);
    endfunction

    // Compute the model's next contents from the pre-edge controls, then
    // step one clock and sample 1 time unit after the edge.
    task automatic tick();
        inst_t nxt;
        if (rst_i || flush_i) nxt = '0;
        else if (stall_i)     nxt = model;
        else                  nxt = capture_id();
        @(posedge clk_i);
        model = nxt;
        #1;
    endtask

    task automatic check_outputs(input string tag);
        logic [DW-1:0] rt_fwd;
        rt_fwd = exp_fwd(EX_RtOverride_i, model.rt);
        check({tag, " valid"},    valid_o,    model.valid);
        check({tag, " RegWrite"}, RegWrite_o, model.rw);
        check({tag, " MemtoReg"}, MemtoReg_o, model.mtr);
        check({tag, " MemRead"},  MemRead_o,  model.mr);
        check({tag, " MemWrite"}, MemWrite_o, model.mw);
        check({tag, " ALUSrc"},   ALUSrc_o,   model.as);
        check({tag, " ALUOp"},    ALUOp_o,    model.op);
        check({tag, " funct"},    funct_o,    model.fn);
        check({tag, " RsAddr"},   ID_EX_RsAddr_o, model.rsa);
        check({tag, " RtAddr"},   ID_EX_RtAddr_o, model.rta);
        check({tag, " RdAddr"},   ID_EX_RdAddr_o, model.rda);
        check({tag, " ALUSrcA"},  ALUSrcA_o,  exp_fwd(EX_RsOverride_i, model.rs));
        check({tag, " ALUSrcB"},  ALUSrcB_o,  model.as ? model.imm : rt_fwd);
        check({tag, " StoreData"}, StoreData_o, rt_fwd);
        check({tag, " hazard"},   hazard_o,   exp_hazard());
    endtask

    task automatic rand_id();
        RegWrite_i = 1'($urandom); MemtoReg_i = 1'($urandom);
        MemRead_i  = 1'($urandom); MemWrite_i = 1'($urandom);
        ALUSrc_i   = 1'($urandom); ALUOp_i    = 2'($urandom);
        funct_i    = 10'($urandom);
        RsData_i = $urandom; RtData_i = $urandom; Imm_i = $urandom;
        RsAddr_i = 5'($urandom);
        RtAddr_i = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        RdAddr_i = 5'($urandom);
    endtask

    task automatic rand_side();
        EX_RsOverride_i = 2'($urandom); EX_RtOverride_i = 2'($urandom);
        EX_MEM_ALUResult_i = $urandom; MEM_WB_WriteData_i = $urandom;
        IF_ID_RsAddr_i = 5'($urandom_range(0, 3));
        IF_ID_RtAddr_i = 5'($urandom_range(0, 3));
    endtask

    task automatic set_inst(input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                            input logic [DW-1:0] imm, input logic as,
                            input logic mr, input logic [AW-1:0] rta);
        RegWrite_i = 1'b1; MemtoReg_i = mr; MemRead_i = mr; MemWrite_i = 1'b0;
        ALUSrc_i = as; ALUOp_i = 2'b10; funct_i = 10'h005;
        RsData_i = rsd; RtData_i = rtd; Imm_i = imm;
        RsAddr_i = 5'd1; RtAddr_i = rta; RdAddr_i = 5'd3;
    endtask

    typedef struct {
        logic [DW-1:0] rsd, rtd, imm;
        logic          as;
        logic [1:0]    rso, rto;
        logic [DW-1:0] exm, mwb;
        logic [DW-1:0] exp_a, exp_b, exp_sd;
    } fwd_vec_t;

    typedef struct {
        logic          mr;
        logic [AW-1:0] rta, ifrs, ifrt;
        logic          exp_haz;
    } haz_vec_t;

    fwd_vec_t fv[5];
    haz_vec_t hv[6];

    initial begin
        fv[0] = '{32'h11, 32'h22, 32'h4, 1'b0, 2'b10, 2'b00, 32'hAAAA, 32'h0,    32'hAAAA, 32'h22,   32'h22};
        fv[1] = '{32'h11, 32'h22, 32'h4, 1'b0, 2'b00, 2'b01, 32'h0,    32'h5555, 32'h11,   32'h5555, 32'h5555};
        fv[2] = '{32'h11, 32'h22, 32'h8, 1'b1, 2'b00, 2'b01, 32'h0,    32'h5555, 32'h11,   32'h8,    32'h5555};
        fv[3] = '{32'h11, 32'h22, 32'h4, 1'b0, 2'b11, 2'b11, 32'hAAAA, 32'h5555, 32'h11,   32'h22,   32'h22};
        fv[4] = '{32'h33, 32'h44, 32'h4, 1'b0, 2'b01, 2'b10, 32'h1234, 32'hDEAD, 32'hDEAD, 32'h1234, 32'h1234};

        hv[0] = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b1};
        hv[1] = '{1'b1, 5'd5,  5'd0,  5'd5, 1'b1};
        hv[2] = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b0};
        hv[3] = '{1'b0, 5'd5,  5'd5,  5'd5, 1'b0};
        hv[4] = '{1'b1, 5'd5,  5'd6,  5'd7, 1'b0};
        hv[5] = '{1'b1, 5'd31, 5'd31, 5'd3, 1'b1};

        // Reset: every output is zero while rst_i is high.
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        set_inst(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        EX_RsOverride_i = 2'b00; EX_RtOverride_i = 2'b00;
        EX_MEM_ALUResult_i = '0; MEM_WB_WriteData_i = '0;
        IF_ID_RsAddr_i = '0; IF_ID_RtAddr_i = '0;
        model = '0;
        tick(); tick();
        check_outputs("reset");

        // Release reset; the first edge after release performs a load.
        rst_i = 1'b0;
        set_inst(32'h11, 32'h22, 32'h4, 1'b0, 1'b0, 5'd2);
        tick();
        check("first_load ALUSrcA", ALUSrcA_o, 32'h11);
        check("first_load ALUSrcB", ALUSrcB_o, 32'h22);
        check("first_load valid",   valid_o,   1'b1);
        check_outputs("first_load");

        // Forwarding and operand-select table.
        for (int i = 0; i < 5; i++) begin
            set_inst(fv[i].rsd, fv[i].rtd, fv[i].imm, fv[i].as, 1'b0, 5'd2);
            EX_RsOverride_i = 2'b00; EX_RtOverride_i = 2'b00;
            tick();
            EX_RsOverride_i = fv[i].rso; EX_RtOverride_i = fv[i].rto;
            EX_MEM_ALUResult_i = fv[i].exm; MEM_WB_WriteData_i = fv[i].mwb;
            #1;
            check($sformatf("fwd[%0d] ALUSrcA", i), ALUSrcA_o, fv[i].exp_a);
            check($sformatf("fwd[%0d] ALUSrcB", i), ALUSrcB_o, fv[i].exp_b);
            check($sformatf("fwd[%0d] StoreData", i), StoreData_o, fv[i].exp_sd);
        end

        // Load-use table.
        EX_RsOverride_i = 2'b00; EX_RtOverride_i = 2'b00;
        for (int i = 0; i < 6; i++) begin
            IF_ID_RsAddr_i = 5'd9; IF_ID_RtAddr_i = 5'd9;
            set_inst(32'h1, 32'h2, 32'h3, 1'b1, hv[i].mr, hv[i].rta);
            tick();
            IF_ID_RsAddr_i = hv[i].ifrs; IF_ID_RtAddr_i = hv[i].ifrt;
            #1;
            check($sformatf("haz[%0d] hazard", i), hazard_o, hv[i].exp_haz);
        end

        // Stall for 3 cycles while the ID inputs keep changing.
        set_inst(32'hCAFE, 32'hBEEF, 32'h10, 1'b0, 1'b1, 5'd7);
        IF_ID_RsAddr_i = 5'd7; IF_ID_RtAddr_i = 5'd0;
        tick();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            tick();
            check_outputs($sformatf("stall[%0d]", i));
            check($sformatf("stall[%0d] ALUSrcA", i), ALUSrcA_o, 32'hCAFE);
        end

        // Flush and stall together: flush wins and loads a bubble.
        flush_i = 1'b1;
        tick();
        check("flush valid",    valid_o, 1'b0);
        check("flush RegWrite", RegWrite_o, 1'b0);
        check("flush RtAddr",   ID_EX_RtAddr_o, 5'd0);
        check("flush RsAddr",   ID_EX_RsAddr_o, 5'd0);
        check_outputs("flush");

        // A stalled bubble stays a bubble and never raises a hazard.
        flush_i = 1'b0;
        IF_ID_RsAddr_i = 5'd0; IF_ID_RtAddr_i = 5'd0;
        set_inst(32'h1, 32'h2, 32'h3, 1'b0, 1'b1, 5'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("bubble_stall[%0d] valid", i), valid_o, 1'b0);
            check($sformatf("bubble_stall[%0d] hazard", i), hazard_o, 1'b0);
        end
        stall_i = 1'b0;

        // Asynchronous reset between edges drops a valid instruction at once.
        set_inst(32'h77, 32'h88, 32'h9, 1'b1, 1'b1, 5'd4);
        IF_ID_RsAddr_i = 5'd4;
        tick();
        check("pre_async valid", valid_o, 1'b1);
        #2;
        rst_i = 1'b1;
        model = '0;
        #1;
        check("async_rst valid",   valid_o, 1'b0);
        check("async_rst ALUSrcA", ALUSrcA_o, 32'h0);
        check_outputs("async_rst");
        tick();
        rst_i = 1'b0;

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            rand_id();
            rand_side();
            flush_i = ($urandom_range(0, 7) == 0);
            stall_i = ($urandom_range(0, 3) == 0);
            rst_i   = ($urandom_range(0, 31) == 0);
            if (rst_i) model = '0;
            tick();
            check_outputs($sformatf("rand[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
